// File: rtl/dmem_arb_pkg.sv
// ---------------------------------------------------------------------------
// dmem_arb_pkg
// Shared types and helpers for the two-port data-memory arbiter.
//   state_e    : arbiter FSM states (IDLE, ACCESS, RESP)
//   F3_*       : RISC-V load/store width codes (func3)
//   port_id_t  : requester index (0 = load/store unit, 1 = aux master)
//   is_legal() : func3 legality check for a load or a store
// Optional build macro used by the arbiter: DMEM_ARB_RR_EN (round-robin).
// ---------------------------------------------------------------------------
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef logic port_id_t;

  // Stores only come in signed widths; loads additionally allow the
  // zero-extending byte/half forms.
  function automatic logic is_legal(input logic we, input logic [2:0] func3);
    logic ok;
    if (we) begin
      ok = (func3 == F3_B) || (func3 == F3_H) || (func3 == F3_W);
    end else begin
      ok = (func3 == F3_B) || (func3 == F3_H) || (func3 == F3_W) ||
           (func3 == F3_BU) || (func3 == F3_HU);
    end
    return ok;
  endfunction

endpackage

// File: rtl/dmem_rr_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_rr_arbiter
// Two-way grant logic for the data-memory arbiter.
//   req_i [1:0] : request per port
//   en_i        : grants allowed this cycle (arbiter idle and out of reset)
//   ptr_i       : preferred port (round-robin build only)
//   gnt_o [1:0] : one-hot grant, or zero when nothing is granted
// Build option: DMEM_ARB_RR_EN
//   defined   -> round-robin, the port named by ptr_i wins a tie
//   undefined -> fixed priority, port 0 always wins a tie
// ---------------------------------------------------------------------------
module dmem_rr_arbiter
  import dmem_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       en_i,
  input  port_id_t   ptr_i,
  output logic [1:0] gnt_o
);

`ifdef DMEM_ARB_RR_EN
  port_id_t other;
  assign other = ~ptr_i;

  always_comb begin
    gnt_o = 2'b00;
    if (en_i) begin
      if (req_i[ptr_i]) begin
        gnt_o[ptr_i] = 1'b1;
      end else if (req_i[other]) begin
        gnt_o[other] = 1'b1;
      end
    end
  end
`else
  // The pointer has no meaning under fixed priority.
  logic unused_ptr;
  assign unused_ptr = ptr_i;

  always_comb begin
    gnt_o = 2'b00;
    if (en_i) begin
      if (req_i[0]) begin
        gnt_o = 2'b01;
      end else if (req_i[1]) begin
        gnt_o = 2'b10;
      end
    end
  end
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
// Shares the single data-memory port between the pipeline load/store unit
// (port 0) and an auxiliary master (port 1). One transaction at a time:
//   IDLE   : grant one valid port, pulse its req_ready, latch the request
//   ACCESS : check legality, drive the memory for exactly one cycle,
//            capture load data / error into the response registers
//   RESP   : hold rsp_valid for the owning port until rsp_ready
// Accept at cycle N -> rsp_valid at N+2; at most one request per 3 cycles.
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   req_valid/ready [2]        request handshake per port
//   req_addr/wdata/we/func3    request payload per port
//   rsp_valid [2], rsp_ready[2] response handshake per port
//   rsp_rdata, rsp_err         shared response data / error flag
//   mem_addr/wdata/read/write/func3, mem_rdata   memory interface
// Build option: DMEM_ARB_RR_EN selects round-robin instead of fixed
// priority (see dmem_rr_arbiter); ports and timing are identical.
// ---------------------------------------------------------------------------
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MEM_DEPTH = 40
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [1:0]             req_valid,
  output logic [1:0]             req_ready,
  input  logic [1:0][ADDR_W-1:0] req_addr,
  input  logic [1:0][DATA_W-1:0] req_wdata,
  input  logic [1:0]             req_we,
  input  logic [1:0][2:0]        req_func3,
  output logic [1:0]             rsp_valid,
  input  logic [1:0]             rsp_ready,
  output logic [DATA_W-1:0]      rsp_rdata,
  output logic                   rsp_err,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic [DATA_W-1:0]      mem_wdata,
  output logic                   mem_read,
  output logic                   mem_write,
  output logic [2:0]             mem_func3,
  input  logic [DATA_W-1:0]      mem_rdata
);

  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(MEM_DEPTH);

  state_e              state_q;
  port_id_t            id_q;
  port_id_t            ptr_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                we_q;
  logic [2:0]          func3_q;
  logic [1:0]          rsp_valid_q;
  logic                rsp_err_q;
  logic [DATA_W-1:0]   rsp_rdata_q;

  logic [1:0]          gnt;
  port_id_t            gnt_id;
  logic                legal;
  logic                rsp_err_d;
  logic [DATA_W-1:0]   rsp_rdata_d;

  // Grants are only issued from IDLE; holding en low in reset keeps a
  // request from seeing a ready that the reset edge would then discard.
  dmem_rr_arbiter u_arb (
    .req_i (req_valid),
    .en_i  ((state_q == IDLE) && rst_n),
    .ptr_i (ptr_q),
    .gnt_o (gnt)
  );

  assign gnt_id    = gnt[1];
  assign req_ready = gnt;

  assign legal = (addr_q < DEPTH_A) && is_legal(we_q, func3_q);

  // Memory strobes exist only during ACCESS of a legal request, and are
  // gated by rst_n so a reset landing mid-ACCESS can never write.
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_func3 = func3_q;
  assign mem_read  = rst_n && (state_q == ACCESS) && legal && !we_q;
  assign mem_write = rst_n && (state_q == ACCESS) && legal &&  we_q;

  // Response contents captured at the end of ACCESS. Stores and rejected
  // requests return zero data.
  always_comb begin
    rsp_err_d   = !legal;
    rsp_rdata_d = '0;
    if (legal && !we_q) begin
      rsp_rdata_d = mem_rdata;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      id_q        <= 1'b0;
      ptr_q       <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      func3_q     <= 3'b000;
      rsp_valid_q <= 2'b00;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (gnt != 2'b00) begin
            state_q <= ACCESS;
            id_q    <= gnt_id;
            ptr_q   <= ~gnt_id;
            addr_q  <= req_addr[gnt_id];
            wdata_q <= req_wdata[gnt_id];
            we_q    <= req_we[gnt_id];
            func3_q <= req_func3[gnt_id];
          end
        end
        ACCESS: begin
          state_q     <= RESP;
          rsp_err_q   <= rsp_err_d;
          rsp_rdata_q <= rsp_rdata_d;
          rsp_valid_q <= {id_q, ~id_q};
        end
        RESP: begin
          if ((rsp_valid_q & rsp_ready) != 2'b00) begin
            state_q     <= IDLE;
            rsp_valid_q <= 2'b00;
          end
        end
        default: begin
          state_q     <= IDLE;
          rsp_valid_q <= 2'b00;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
`timescale 1ns/1ps
module tb_dmem_arbiter;

  localparam int ADDR_W    = 32;
  localparam int DATA_W    = 32;
  localparam int MEM_DEPTH = 40;
  localparam int TMO       = 40;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        port;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  f3;
    logic        err;
    logic [31:0] rdata;
  } vec_t;

  typedef struct {
    logic        port;
    logic        err;
    logic [31:0] rdata;
    int          acc;
  } sb_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  f3;
  } req_t;

  logic        rst_n;
  logic        v0, v1;
  req_t        pr0, pr1;
  logic [1:0]  rsp_rdy;
  logic [1:0]  req_ready, rsp_valid;
  logic [31:0] rsp_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        rsp_err, mem_read, mem_write;
  logic [2:0]  mem_func3;

  dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_DEPTH(MEM_DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid ({v1, v0}),
    .req_ready (req_ready),
    .req_addr  ({pr1.addr, pr0.addr}),
    .req_wdata ({pr1.wdata, pr0.wdata}),
    .req_we    ({pr1.we, pr0.we}),
    .req_func3 ({pr1.f3, pr0.f3}),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_rdy),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_func3 (mem_func3),
    .mem_rdata (mem_rdata)
  );

  // ---- data memory model: word addressed, combinational read ----
  logic [31:0] mem [0:63];
  logic        mem_clr;
  logic [31:0] word;
  int          cyc = 0;
  int          wr_cnt = 0;
  int          rd_cnt = 0;

  always_comb begin
    word = (mem_addr < 32'd64) ? mem[mem_addr[5:0]] : 32'h0;
    case (mem_func3)
      3'b000:  mem_rdata = {{24{word[7]}}, word[7:0]};
      3'b001:  mem_rdata = {{16{word[15]}}, word[15:0]};
      3'b100:  mem_rdata = {24'h0, word[7:0]};
      3'b101:  mem_rdata = {16'h0, word[15:0]};
      default: mem_rdata = word;
    endcase
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_write) wr_cnt <= wr_cnt + 1;
    if (mem_read)  rd_cnt <= rd_cnt + 1;
    if (mem_clr) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
    end else if (mem_write && mem_addr < 32'd64) begin
      case (mem_func3)
        3'b000:  mem[mem_addr[5:0]][7:0]  <= mem_wdata[7:0];
        3'b001:  mem[mem_addr[5:0]][15:0] <= mem_wdata[15:0];
        default: mem[mem_addr[5:0]]       <= mem_wdata;
      endcase
    end
  end

  // ---- bookkeeping ----
  int   n_chk = 0;
  int   n_fail = 0;
  sb_t  sb[$];
  logic grant_log[$];
  sb_t  exp_cur[2];
  bit   pending[2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: bound expired (t=%0t)", name, $time);
  endtask

  // Monitor: grant tracking, scoreboard pop, latency and invariants.
  task automatic monitor();
    logic [1:0] prev_rv = 2'b00;
    sb_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_rv = 2'b00;
      end else begin
        chk("ready_without_valid", {30'h0, req_ready & ~{v1, v0}}, 32'h0);
        for (int p = 0; p < 2; p++) begin
          if (req_ready[p]) begin
            chk("grant_expected", {31'h0, pending[p]}, 32'h1);
            e = exp_cur[p];
            e.acc = cyc;
            sb.push_back(e);
            grant_log.push_back(p[0]);
          end
        end
        if (rsp_valid != 2'b00 && prev_rv == 2'b00) begin
          if (sb.size() == 0) fail_now("rsp_without_request");
          else chk("rsp_latency", cyc - sb[0].acc, 32'd2);
        end
        if ((rsp_valid & rsp_rdy) != 2'b00 && sb.size() != 0) begin
          e = sb.pop_front();
          chk("rsp_port", {30'h0, rsp_valid}, e.port ? 32'h2 : 32'h1);
          chk("rsp_err", {31'h0, rsp_err}, {31'h0, e.err});
          chk("rsp_rdata", rsp_rdata, e.rdata);
        end
        prev_rv = rsp_valid;
      end
    end
  endtask

  task automatic raise(input vec_t v);
    req_t r;
    @(posedge clk); #1;
    r.we = v.we; r.addr = v.addr; r.wdata = v.wdata; r.f3 = v.f3;
    exp_cur[v.port] = '{port: v.port, err: v.err, rdata: v.rdata, acc: 0};
    pending[v.port] = 1'b1;
    if (v.port == 1'b0) begin pr0 = r; v0 = 1'b1; end
    else                begin pr1 = r; v1 = 1'b1; end
  endtask

  task automatic wait_accept(input logic p);
    int k = 0;
    bit got = 0;
    while (!got && k < TMO) begin
      @(negedge clk);
      got = req_ready[p];
      k++;
    end
    if (!got) fail_now(p ? "accept_p1" : "accept_p0");
    @(posedge clk); #1;
    if (p == 1'b0) v0 = 1'b0; else v1 = 1'b0;
    pending[p] = 1'b0;
  endtask

  task automatic issue(input vec_t v);
    raise(v);
    wait_accept(v.port);
  endtask

  task automatic drain();
    int k = 0;
    while (sb.size() != 0 && k < TMO) begin
      @(negedge clk);
      k++;
    end
    if (sb.size() != 0) begin
      fail_now("drain");
      sb.delete();
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  localparam int NV = 20;
  vec_t vecs [NV];
  vec_t va, vb;
  int   w0, r0;
  logic [31:0] held;
  logic exp_order [8];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    //         port we  addr          wdata          f3      err   rdata
    vecs[0]  = '{1'b0, 1'b1, 32'd5,  32'hDEADBEEF, 3'b010, 1'b0, 32'h0};
    vecs[1]  = '{1'b0, 1'b0, 32'd5,  32'h0,        3'b010, 1'b0, 32'hDEADBEEF};
    vecs[2]  = '{1'b1, 1'b1, 32'd3,  32'h000000F0, 3'b010, 1'b0, 32'h0};
    vecs[3]  = '{1'b1, 1'b0, 32'd3,  32'h0,        3'b000, 1'b0, 32'hFFFFFFF0};
    vecs[4]  = '{1'b1, 1'b0, 32'd3,  32'h0,        3'b100, 1'b0, 32'h000000F0};
    vecs[5]  = '{1'b0, 1'b0, 32'd5,  32'h0,        3'b001, 1'b0, 32'hFFFFBEEF};
    vecs[6]  = '{1'b0, 1'b0, 32'd5,  32'h0,        3'b101, 1'b0, 32'h0000BEEF};
    vecs[7]  = '{1'b1, 1'b1, 32'd5,  32'h00000011, 3'b000, 1'b0, 32'h0};
    vecs[8]  = '{1'b0, 1'b0, 32'd5,  32'h0,        3'b010, 1'b0, 32'hDEADBE11};
    vecs[9]  = '{1'b0, 1'b1, 32'd6,  32'h12345678, 3'b001, 1'b0, 32'h0};
    vecs[10] = '{1'b1, 1'b0, 32'd6,  32'h0,        3'b010, 1'b0, 32'h00005678};
    vecs[11] = '{1'b0, 1'b0, 32'd40, 32'h0,        3'b010, 1'b1, 32'h0};
    vecs[12] = '{1'b1, 1'b1, 32'd5,  32'hCAFEF00D, 3'b100, 1'b1, 32'h0};
    vecs[13] = '{1'b0, 1'b0, 32'd5,  32'h0,        3'b010, 1'b0, 32'hDEADBE11};
    vecs[14] = '{1'b0, 1'b0, 32'd5,  32'h0,        3'b011, 1'b1, 32'h0};
    vecs[15] = '{1'b1, 1'b1, 32'd5,  32'h0,        3'b011, 1'b1, 32'h0};
    vecs[16] = '{1'b0, 1'b0, 32'd39, 32'h0,        3'b010, 1'b0, 32'h0};
    vecs[17] = '{1'b1, 1'b1, 32'd39, 32'hA5A5A5A5, 3'b010, 1'b0, 32'h0};
    vecs[18] = '{1'b1, 1'b0, 32'd39, 32'h0,        3'b100, 1'b0, 32'h000000A5};
    vecs[19] = '{1'b0, 1'b0, 32'hFFFFFFFF, 32'h0,  3'b010, 1'b1, 32'h0};

    rst_n = 1'b0; v0 = 1'b0; v1 = 1'b0; rsp_rdy = 2'b11; mem_clr = 1'b1;
    pr0 = '{1'b0, 32'h0, 32'h0, 3'b000};
    pr1 = '{1'b0, 32'h0, 32'h0, 3'b000};
    pending[0] = 0; pending[1] = 0;
    exp_cur[0] = '{1'b0, 1'b0, 32'h0, 0};
    exp_cur[1] = '{1'b1, 1'b0, 32'h0, 0};
    fork monitor(); join_none

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rsp_valid", {30'h0, rsp_valid}, 32'h0);
    chk("rst_rsp_err", {31'h0, rsp_err}, 32'h0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk("rst_mem_strobes", {30'h0, mem_read, mem_write}, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    @(posedge clk); #1;
    mem_clr = 1'b0; rst_n = 1'b1;

    // Table vectors, one transaction at a time
    for (int i = 0; i < NV; i++) begin
      w0 = wr_cnt; r0 = rd_cnt;
      issue(vecs[i]);
      drain();
      chk($sformatf("v%0d_writes", i), wr_cnt - w0,
          (!vecs[i].err && vecs[i].we) ? 32'd1 : 32'd0);
      chk($sformatf("v%0d_reads", i), rd_cnt - r0,
          (!vecs[i].err && !vecs[i].we) ? 32'd1 : 32'd0);
    end

    // Contention: 4 loads per port, both valid continuously
    do_reset();
    va = '{1'b0, 1'b0, 32'd5, 32'h0, 3'b010, 1'b0, 32'hDEADBE11};
    vb = '{1'b1, 1'b0, 32'd3, 32'h0, 3'b010, 1'b0, 32'h000000F0};
`ifdef DMEM_ARB_RR_EN
    exp_order = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
`else
    exp_order = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
`endif
    grant_log.delete();
    fork
      begin for (int k = 0; k < 4; k++) issue(va); end
      begin for (int k = 0; k < 4; k++) issue(vb); end
    join
    drain();
    chk("grant_count", grant_log.size(), 32'd8);
    for (int k = 0; k < 8; k++) begin
      if (k < grant_log.size())
        chk($sformatf("grant_%0d", k), {31'h0, grant_log[k]}, {31'h0, exp_order[k]});
    end

    // A port that drops valid outside IDLE is never granted
    grant_log.delete();
    raise(va);
    wait_accept(1'b0);
    v1 = 1'b1;
    pr1 = '{1'b0, 32'd3, 32'h0, 3'b010};
    @(posedge clk); #1;
    v1 = 1'b0;
    drain();
    repeat (3) @(negedge clk);
    chk("dropped_valid_grants", grant_log.size(), 32'd1);

    // Response stall with port 1 waiting
    rsp_rdy = 2'b00;
    raise(va);
    wait_accept(1'b0);
    raise(vb);
    begin
      int k = 0;
      while (!rsp_valid[0] && k < TMO) begin @(negedge clk); k++; end
      if (!rsp_valid[0]) fail_now("stall_rsp_valid");
    end
    held = rsp_rdata;
    chk("stall_rdata", held, 32'hDEADBE11);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("stall_valid", {30'h0, rsp_valid}, 32'h1);
      chk("stall_hold", rsp_rdata, held);
      chk("stall_req_ready", {30'h0, req_ready}, 32'h0);
    end
    @(posedge clk); #1;
    rsp_rdy = 2'b11;
    wait_accept(1'b1);
    drain();

    // Reset during ACCESS of a store
    raise('{1'b0, 1'b1, 32'd7, 32'h00000055, 3'b010, 1'b0, 32'h0});
    wait_accept(1'b0);
    rst_n = 1'b0;
    w0 = wr_cnt;
    @(negedge clk);
    chk("rstacc_mem_write", {31'h0, mem_write}, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    sb.delete();
    @(negedge clk);
    chk("rstacc_rsp_valid", {30'h0, rsp_valid}, 32'h0);
    chk("rstacc_writes", wr_cnt - w0, 32'd0);
    chk("rstacc_mem7", mem[7], 32'h0);
    issue('{1'b0, 1'b0, 32'd7, 32'h0, 3'b010, 1'b0, 32'h0});
    drain();
    issue('{1'b1, 1'b1, 32'd7, 32'h00000077, 3'b010, 1'b0, 32'h0});
    drain();
    issue('{1'b1, 1'b0, 32'd7, 32'h0, 3'b010, 1'b0, 32'h00000077});
    drain();

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
    $finish;
  end

endmodule
